// File: rtl/uart_rx_sampler_param.sv
// Oversampling majority-vote bit sampler for the UART RX path, with optional input synchroniser.
// Optional feature: define UART_RX_SAMPLE_NOISE_EN to add the noise_err vote-disagreement pulse.
module uart_rx_sampler_param #(
    parameter int unsigned PRESC_W     = 6,
    parameter int unsigned NUM_VOTES   = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               RX_IN,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic               data_sample_en,
    input  logic [PRESC_W-1:0] edge_count,
    input  logic               single_mode,
    output logic               sampled_bit,
    output logic               sample_valid,
    output logic               cfg_err
`ifdef UART_RX_SAMPLE_NOISE_EN
    ,
    output logic               noise_err
`endif
);

    localparam int unsigned K     = (NUM_VOTES - 1) / 2;
    localparam int unsigned CNT_W = $clog2(NUM_VOTES + 1);
    localparam int unsigned TOT_W = CNT_W + 1;
    localparam int unsigned PW1   = PRESC_W + 1;

    logic rx_s;

    // Input synchroniser; flops reset to the idle-high line level.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign rx_s = RX_IN;
        end else if (SYNC_STAGES == 1) begin : g_sync1
            logic sync_q;
            always_ff @(posedge clk) begin
                if (!rst) sync_q <= 1'b1;
                else      sync_q <= RX_IN;
            end
            assign rx_s = sync_q;
        end else begin : g_syncn
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk) begin
                if (!rst) sync_q <= '1;
                else      sync_q <= {sync_q[SYNC_STAGES-2:0], RX_IN};
            end
            assign rx_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [CNT_W-1:0]   ones_q, ones_d;
    logic [PRESC_W-1:0] presc_q;
    logic               mid_q, mid_d;
    logic               bit_d, valid_d, cfg_err_d;

    logic [PW1-1:0]   presc_x, edge_x, half_x, win_lo_x, win_hi_x;
    logic             legal_c, run_c, in_win_c, clear_c, decide_c, at_mid_c, mid_c;
    logic [TOT_W-1:0] tot_c;

    // Window is computed one bit wider so H+K cannot wrap.
    assign presc_x  = PW1'(Prescale);
    assign edge_x   = PW1'(edge_count);
    assign half_x   = PW1'(Prescale >> 1);
    assign win_lo_x = half_x - PW1'(K);
    assign win_hi_x = half_x + PW1'(K);

    assign legal_c  = !Prescale[0] && (presc_x >= PW1'(2 * K + 2));
    assign run_c    = data_sample_en && legal_c;
    assign in_win_c = (edge_x >= win_lo_x) && (edge_x <= win_hi_x);
    assign at_mid_c = (edge_x == half_x);
    assign clear_c  = !data_sample_en || (edge_x == presc_x - PW1'(1)) || (Prescale != presc_q);
    assign decide_c = run_c && (edge_x == win_hi_x);
    assign tot_c    = TOT_W'(ones_q) + TOT_W'(rx_s);
    assign mid_c    = at_mid_c ? rx_s : mid_q;

    // Vote accumulation and decision.
    always_comb begin
        ones_d    = ones_q;
        mid_d     = mid_q;
        bit_d     = sampled_bit;
        valid_d   = 1'b0;
        cfg_err_d = !legal_c;
        if (clear_c) begin
            ones_d = '0;
        end else if (run_c && in_win_c) begin
            ones_d = ones_q + CNT_W'(rx_s);
        end
        if (run_c && at_mid_c) begin
            mid_d = rx_s;
        end
        if (decide_c) begin
            valid_d = 1'b1;
            bit_d   = single_mode ? mid_c : (tot_c > TOT_W'(K));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ones_q       <= '0;
            presc_q      <= '0;
            mid_q        <= 1'b0;
            sampled_bit  <= 1'b0;
            sample_valid <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            ones_q       <= ones_d;
            presc_q      <= Prescale;
            mid_q        <= mid_d;
            sampled_bit  <= bit_d;
            sample_valid <= valid_d;
            cfg_err      <= cfg_err_d;
        end
    end

`ifdef UART_RX_SAMPLE_NOISE_EN
    logic noise_d;
    assign noise_d = decide_c && (tot_c != '0) && (tot_c < TOT_W'(NUM_VOTES));

    always_ff @(posedge clk) begin
        if (!rst) noise_err <= 1'b0;
        else      noise_err <= noise_d;
    end
`endif

endmodule

// File: tb/tb_uart_rx_sampler_param.sv
// Scoreboard bench for uart_rx_sampler_param: a 3-vote unsynchronised instance and a
// 5-vote instance with a 2-flop synchroniser share one stimulus stream.
module tb_uart_rx_sampler_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX_IN, en, single;
    logic [5:0] presc, edge_cnt;
    logic       a_bit, a_val, a_cfg, b_bit, b_val, b_cfg;
`ifdef UART_RX_SAMPLE_NOISE_EN
    logic       a_noise, b_noise;
`endif

    always #5 clk = ~clk;

    uart_rx_sampler_param #(.PRESC_W(6), .NUM_VOTES(3), .SYNC_STAGES(0)) u_a (
        .clk(clk), .rst(rst), .RX_IN(RX_IN), .Prescale(presc), .data_sample_en(en),
        .edge_count(edge_cnt), .single_mode(single), .sampled_bit(a_bit),
        .sample_valid(a_val), .cfg_err(a_cfg)
`ifdef UART_RX_SAMPLE_NOISE_EN
        , .noise_err(a_noise)
`endif
    );

    uart_rx_sampler_param #(.PRESC_W(6), .NUM_VOTES(5), .SYNC_STAGES(2)) u_b (
        .clk(clk), .rst(rst), .RX_IN(RX_IN), .Prescale(presc), .data_sample_en(en),
        .edge_count(edge_cnt), .single_mode(single), .sampled_bit(b_bit),
        .sample_valid(b_val), .cfg_err(b_cfg)
`ifdef UART_RX_SAMPLE_NOISE_EN
        , .noise_err(b_noise)
`endif
    );

    typedef struct {
        logic b;
        logic n;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t xa, xb;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic last_a, last_b, last_rx;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference vote: sample at edge e is the line value driven s clocks earlier.
    function automatic exp_t model(input int p, input logic [63:0] pat, input logic prev,
                                   input int nv, input int s, input logic sgl);
        int   h;
        int   k;
        int   tot;
        logic v;
        logic mid;
        exp_t r;
        h   = p / 2;
        k   = (nv - 1) / 2;
        tot = 0;
        mid = 1'b0;
        for (int e = h - k; e <= h + k; e++) begin
            v = (e - s >= 0) ? pat[e - s] : prev;
            tot += int'(v);
            if (e == h) mid = v;
        end
        r.b = sgl ? mid : (tot > k);
        r.n = (tot > 0) && (tot < nv);
        return r;
    endfunction

    // Output monitor: every valid pulse must match the oldest expected bit.
    always @(negedge clk) begin
        if (rst) begin
            if (a_val) begin
                if (qa.size() == 0) check_eq("a_spurious_valid", a_val, 0);
                else begin
                    xa = qa.pop_front();
                    check_eq("a_bit", a_bit, xa.b);
`ifdef UART_RX_SAMPLE_NOISE_EN
                    check_eq("a_noise", a_noise, xa.n);
`endif
                end
            end
            if (b_val) begin
                if (qb.size() == 0) check_eq("b_spurious_valid", b_val, 0);
                else begin
                    xb = qb.pop_front();
                    check_eq("b_bit", b_bit, xb.b);
`ifdef UART_RX_SAMPLE_NOISE_EN
                    check_eq("b_noise", b_noise, xb.n);
`endif
                end
            end
        end
    end

    // kind: 0 normal bit, 1 enable dropped from abort_at, 2 reset pulse at abort_at.
    task automatic drive_bit(input int p, input logic [63:0] pat, input logic sgl,
                             input int kind, input int abort_at);
        logic leg_a;
        logic leg_b;
        exp_t ea;
        exp_t eb;
        leg_a = (p % 2 == 0) && (p >= 4);
        leg_b = (p % 2 == 0) && (p >= 6);
        if (kind == 0 && leg_a) begin
            ea = model(p, pat, last_rx, 3, 0, sgl);
            qa.push_back(ea);
            last_a = ea.b;
        end
        if (kind == 0 && leg_b) begin
            eb = model(p, pat, last_rx, 5, 2, sgl);
            qb.push_back(eb);
            last_b = eb.b;
        end
        for (int e = 0; e < p; e++) begin
            @(negedge clk);
            if (e == 1) begin
                check_eq("a_cfg_err", a_cfg, !leg_a);
                check_eq("b_cfg_err", b_cfg, !leg_b);
            end
            if (kind == 2 && e == abort_at + 1) begin
                check_eq("a_rst_bit", a_bit, 0);
                check_eq("a_rst_valid", a_val, 0);
                check_eq("a_rst_cfg", a_cfg, 0);
                check_eq("b_rst_bit", b_bit, 0);
                check_eq("b_rst_valid", b_val, 0);
                check_eq("b_rst_cfg", b_cfg, 0);
                last_a = 1'b0;
                last_b = 1'b0;
            end
            if (kind == 1 && e == p - 1) begin
                check_eq("a_hold", a_bit, last_a);
                check_eq("b_hold", b_bit, last_b);
            end
            rst      = !(kind == 2 && e == abort_at);
            presc    = 6'(p);
            edge_cnt = 6'(e);
            RX_IN    = pat[e];
            single   = sgl;
            en       = !(kind != 0 && e >= abort_at);
        end
        last_rx = pat[p - 1];
    endtask

    initial begin
        logic [63:0] pat;
        int          plist [5] = '{8, 10, 12, 16, 32};

        rst = 1'b0; RX_IN = 1'b1; en = 1'b0; single = 1'b0; presc = 6'd8; edge_cnt = '0;
        last_a = 1'b0; last_b = 1'b0; last_rx = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("a_reset_bit", a_bit, 0);
        check_eq("a_reset_valid", a_val, 0);
        check_eq("a_reset_cfg", a_cfg, 0);
        check_eq("b_reset_bit", b_bit, 0);
        check_eq("b_reset_valid", b_val, 0);
        check_eq("b_reset_cfg", b_cfg, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // All-ones bit at Prescale 8.
        drive_bit(8, '1, 1'b0, 0, 0);
        // Single one at edge 7 of Prescale 16, then an all-zero bit.
        pat = '0; pat[7] = 1'b1;
        drive_bit(16, pat, 1'b0, 0, 0);
        drive_bit(16, '0, 1'b0, 0, 0);
        // Ones at 14, 15, 17 of Prescale 32; then centre-only with a zero at 16.
        pat = '0; pat[14] = 1'b1; pat[15] = 1'b1; pat[17] = 1'b1;
        drive_bit(32, pat, 1'b0, 0, 0);
        pat = '1; pat[16] = 1'b0;
        drive_bit(32, pat, 1'b1, 0, 0);

        for (int i = 0; i < 10; i++) begin
            pat = {$urandom, $urandom};
            drive_bit(plist[$urandom_range(4, 0)], pat, 1'($urandom_range(1, 0)), 0, 0);
        end

        // Illegal prescales: no valid pulses over 40+ clocks, then recovery.
        drive_bit(7, '1, 1'b0, 0, 0);
        for (int i = 0; i < 20; i++) drive_bit(2, {$urandom, $urandom}, 1'b0, 0, 0);
        drive_bit(8, '0, 1'b0, 0, 0);
        drive_bit(8, '1, 1'b0, 0, 0);

        // Enable dropped mid-window, then a normal bit.
        drive_bit(16, '0, 1'b0, 1, 8);
        drive_bit(16, '0, 1'b0, 0, 0);

        // Reset mid-window, then a normal bit.
        drive_bit(16, '1, 1'b0, 2, 8);
        pat = '1; pat[8] = 1'b0;
        drive_bit(16, pat, 1'b0, 0, 0);

        @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("a_pending", qa.size(), 0);
        check_eq("b_pending", qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
